up_down_count_checker: RTL and testbench

- Receiving-end monitor for an up/down counter: samples the counter value q with the direction input it was driven with, predicts the next value, and flags deviations.
- Sits beside any up_down_counter instance in the datapath or bench as a self-checking consumer of the count stream.
- Maintains lock status, an error count and wrap-around detection, so counter correctness is checked in hardware.

---
 rtl/up_down_count_checker.sv | 84 ++++++++
 tb/tb_up_down_count_checker.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/up_down_count_checker.sv
// up_down_count_checker: predicts the next value of an up/down counter from its sampled value
// and direction, and reports lock, mismatches, wrap-around and a saturating error count.
module up_down_count_checker #(
  parameter int WIDTH       = 32,
  parameter int ERR_W       = 16,
  parameter int LOSS_THRESH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_up,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_clear,
  output logic             o_locked,
  output logic             o_mismatch,
  output logic             o_wrap,
  output logic [ERR_W-1:0] o_err_count,
  output logic [WIDTH-1:0] o_expected
);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t           r_state;
  logic [3:0]       r_miss_run;
  logic             r_prev_up;
  logic [WIDTH-1:0] w_next;
  logic [3:0]       w_miss_inc;
  logic [ERR_W-1:0] w_err_inc;
  logic             w_hit, w_wrap, w_drop;
  assign w_next     = i_up ? i_q + WIDTH'(1) : i_q - WIDTH'(1);
  assign w_hit      = i_q == o_expected;
  // a matched sample lands on a wrap target only if the previous step crossed the boundary
  assign w_wrap     = r_prev_up ? (i_q == '0) : (i_q == '1);
  assign w_miss_inc = r_miss_run + 4'd1;
  assign w_drop     = w_miss_inc == 4'(LOSS_THRESH);
  assign w_err_inc  = (o_err_count == '1) ? o_err_count : o_err_count + ERR_W'(1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= UNLOCKED;
      r_miss_run  <= '0;
      r_prev_up   <= 1'b0;
      o_locked    <= 1'b0;
      o_mismatch  <= 1'b0;
      o_wrap      <= 1'b0;
      o_err_count <= '0;
      o_expected  <= '0;
    end else if (i_clear) begin
      r_state     <= UNLOCKED;
      r_miss_run  <= '0;
      r_prev_up   <= 1'b0;
      o_locked    <= 1'b0;
      o_mismatch  <= 1'b0;
      o_wrap      <= 1'b0;
      o_err_count <= '0;
      o_expected  <= '0;
    end else if (!i_en) begin
      o_mismatch <= 1'b0;
      o_wrap     <= 1'b0;
    end else begin
      o_expected <= w_next;
      r_prev_up  <= i_up;
      if (r_state == UNLOCKED) begin
        r_state    <= LOCKED;
        o_locked   <= 1'b1;
        r_miss_run <= '0;
        o_mismatch <= 1'b0;
        o_wrap     <= 1'b0;
      end else if (w_hit) begin
        r_miss_run <= '0;
        o_mismatch <= 1'b0;
        o_wrap     <= w_wrap;
      end else begin
        o_mismatch  <= 1'b1;
        o_wrap      <= 1'b0;
        o_err_count <= w_err_inc;
        if (w_drop) begin
          r_state    <= UNLOCKED;
          o_locked   <= 1'b0;
          r_miss_run <= '0;
        end else begin
          r_miss_run <= w_miss_inc;
        end
      end
    end
  end
endmodule

// File: tb/tb_up_down_count_checker.sv
// tb_up_down_count_checker: directed vectors with hand-computed expectations, 4-bit count, 2-bit errors.
module tb_up_down_count_checker;
  logic       i_clk, i_rst_n, i_en, i_up, i_clear;
  logic [3:0] i_q;
  logic       o_locked, o_mismatch, o_wrap;
  logic [1:0] o_err_count;
  logic [3:0] o_expected;
  int         vecs = 0;
  int         errs = 0;

  up_down_count_checker #(.WIDTH(4), .ERR_W(2), .LOSS_THRESH(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_up(i_up), .i_q(i_q), .i_clear(i_clear),
    .o_locked(o_locked), .o_mismatch(o_mismatch), .o_wrap(o_wrap),
    .o_err_count(o_err_count), .o_expected(o_expected)
  );

  initial begin
    i_clk = 1'b0;
    #25;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic up, input logic [3:0] q, input logic clr);
    i_en = en; i_up = up; i_q = q; i_clear = clr;
    @(posedge i_clk);
    #1;
    i_en = 1'b0; i_clear = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b1; i_en = 1'b0; i_up = 1'b0; i_q = '0; i_clear = 1'b0;
    // asynchronous reset, no clock edge yet
    #1 i_rst_n = 1'b0;
    #15;
    chk("rst_locked", o_locked, 0);
    chk("rst_mismatch", o_mismatch, 0);
    chk("rst_wrap", o_wrap, 0);
    chk("rst_err", o_err_count, 0);
    chk("rst_expected", o_expected, 0);
    #2 i_rst_n = 1'b1;
    // up count through the wrap
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 4'(i), 0);
      chk("up_locked", o_locked, 1);
      chk("up_mismatch", o_mismatch, 0);
      chk("up_wrap", o_wrap, 0);
      chk("up_expected", o_expected, (i + 1) % 16);
    end
    step(1, 1, 4'd0, 0);
    chk("up_wrap_pulse", o_wrap, 1);
    chk("up_wrap_mm", o_mismatch, 0);
    step(0, 1, 4'd7, 0);
    chk("up_wrap_end", o_wrap, 0);
    chk("up_hold_exp", o_expected, 1);
    chk("up_err", o_err_count, 0);
    // direction change
    step(0, 0, 4'd0, 1);
    step(1, 1, 4'd4, 0);
    step(1, 0, 4'd5, 0);
    chk("dir_mm1", o_mismatch, 0);
    step(1, 0, 4'd4, 0);
    chk("dir_mm2", o_mismatch, 0);
    step(1, 0, 4'd3, 0);
    chk("dir_mm3", o_mismatch, 0);
    chk("dir_expected", o_expected, 2);
    // down wrap 0 -> 15
    step(0, 0, 4'd0, 1);
    step(1, 0, 4'd1, 0);
    step(1, 0, 4'd0, 0);
    chk("dn_wrap_early", o_wrap, 0);
    step(1, 0, 4'd15, 0);
    chk("dn_wrap_pulse", o_wrap, 1);
    chk("dn_expected", o_expected, 14);
    // single glitch
    step(0, 0, 4'd0, 1);
    step(1, 1, 4'd3, 0);
    step(1, 1, 4'd4, 0);
    step(1, 1, 4'd9, 0);
    chk("gl_mismatch", o_mismatch, 1);
    chk("gl_err", o_err_count, 1);
    chk("gl_locked", o_locked, 1);
    chk("gl_resync", o_expected, 10);
    step(0, 1, 4'd2, 0);
    chk("gl_pulse_end", o_mismatch, 0);
    chk("gl_hold_exp", o_expected, 10);
    step(1, 1, 4'd10, 0);
    chk("gl_match", o_mismatch, 0);
    chk("gl_err_hold", o_err_count, 1);
    // loss of lock
    step(0, 0, 4'd0, 1);
    step(1, 1, 4'd2, 0);
    step(1, 1, 4'd7, 0);
    chk("ll_mm1", o_mismatch, 1);
    chk("ll_lock1", o_locked, 1);
    step(1, 1, 4'd0, 0);
    chk("ll_mm2", o_mismatch, 1);
    chk("ll_lock2", o_locked, 1);
    step(1, 1, 4'd12, 0);
    chk("ll_mm3", o_mismatch, 1);
    chk("ll_lock3", o_locked, 0);
    chk("ll_err", o_err_count, 3);
    chk("ll_expected", o_expected, 13);
    step(1, 1, 4'd5, 0);
    chk("ll_relock", o_locked, 1);
    chk("ll_relock_mm", o_mismatch, 0);
    chk("ll_relock_err", o_err_count, 3);
    chk("ll_relock_exp", o_expected, 6);
    // five more mismatches, err saturates
    step(1, 1, 4'd0, 0);
    step(1, 1, 4'd0, 0);
    step(1, 1, 4'd0, 0);
    chk("sat_drop", o_locked, 0);
    step(1, 1, 4'd0, 0);
    chk("sat_relock_mm", o_mismatch, 0);
    step(1, 1, 4'd0, 0);
    step(1, 1, 4'd0, 0);
    chk("sat_mm", o_mismatch, 1);
    chk("sat_err", o_err_count, 3);
    // clear wins over en
    step(1, 1, 4'd9, 1);
    chk("clr_locked", o_locked, 0);
    chk("clr_err", o_err_count, 0);
    chk("clr_expected", o_expected, 0);
    chk("clr_mismatch", o_mismatch, 0);
    step(1, 0, 4'd8, 0);
    chk("clr_lock_mm", o_mismatch, 0);
    chk("clr_lock_exp", o_expected, 7);
    // asynchronous reset mid-stream
    step(1, 0, 4'd3, 0);
    chk("mid_err_pre", o_err_count, 1);
    i_rst_n = 1'b0;
    #2;
    chk("mid_locked", o_locked, 0);
    chk("mid_err", o_err_count, 0);
    chk("mid_expected", o_expected, 0);
    i_rst_n = 1'b1;
    step(1, 1, 4'd9, 0);
    chk("mid_relock", o_locked, 1);
    chk("mid_relock_mm", o_mismatch, 0);
    chk("mid_relock_exp", o_expected, 10);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
